// File: rtl/mul_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_share_sched
// Purpose  : Round-robin scheduler sharing one pipelined signed multiplier
//            among N_REQ requesters. One operation is in flight at a time.
//            Operands are held stable for the whole multiplier latency, and
//            the product is captured at a fixed cycle because the multiplier
//            has no output-valid. The result is tagged with the owner index.
// Ports    : clk, rst_n       clock, asynchronous active-low reset
//            req_valid/ready  per-requester handshake (ready is one-hot,
//                             combinational, only asserted in IDLE)
//            req_a, req_b     packed operands, requester i at [i*W +: W]
//            mul_a, mul_b     registered operands to the multiplier
//            mul_en           high while an operation is in flight
//            mul_p            multiplier product
//            rsp_valid/ready  result handshake; rsp_id, rsp_p held until taken
//            busy             high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_sched #(
  parameter  int N_REQ   = 4,
  parameter  int W       = 6,
  parameter  int PW      = 2*W-1,
  parameter  int LATENCY = 7,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  output logic               mul_en,
  input  logic [PW-1:0]      mul_p,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [PW-1:0]      rsp_p,
  output logic               busy
);

  localparam int            CW       = $clog2(LATENCY+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);
  localparam logic [IW:0]   N_WRAP   = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          any_valid;
  logic [IW-1:0] win;
  logic [IW-1:0] win_next;
  logic [IW:0]   idx_s;
  logic [IW:0]   nxt_s;
  logic [W-1:0]  win_a;
  logic [W-1:0]  win_b;

  // Round-robin search starting at ptr. The sum ptr+k is at most 2*N_REQ-2,
  // so one conditional subtract is enough to wrap it.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    idx_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, ptr} + (IW+1)'(k);
      if (idx_s >= N_WRAP) idx_s = idx_s - N_WRAP;
      if (!any_valid && req_valid[idx_s[IW-1:0]]) begin
        any_valid = 1'b1;
        win       = idx_s[IW-1:0];
      end
    end
    nxt_s = {1'b0, win} + (IW+1)'(1);
    if (nxt_s >= N_WRAP) nxt_s = '0;
    win_next = nxt_s[IW-1:0];
  end

  assign win_a = req_a[int'(win)*W +: W];
  assign win_b = req_b[int'(win)*W +: W];

  // Grant is only offered from IDLE; RUN and RESP never accept.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            mul_a  <= win_a;
            mul_b  <= win_b;
            rsp_id <= win;
            ptr    <= win_next;
            cnt    <= '0;
            mul_en <= 1'b1;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // Operands became stable at the accept edge; the multiplier needs
          // LATENCY further edges, and the capture happens one edge later.
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
            mul_en    <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_sched
// Purpose  : Self-checking bench for mul_share_sched with a behavioural
//            multiplier that only produces a correct product after its
//            operands have been stable for LATENCY edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_sched;

  localparam int N_REQ   = 4;
  localparam int W       = 6;
  localparam int PW      = 11;
  localparam int LATENCY = 7;
  localparam int IW      = 2;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               mul_en;
  logic [PW-1:0]      mul_p;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [PW-1:0]      rsp_p;
  logic               busy;

  mul_share_sched #(.N_REQ(N_REQ), .W(W), .PW(PW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier model: product is only correct once the operands have been
  // stable for LATENCY edges; otherwise it shows the bitwise inverse.
  logic [W-1:0]    a_q, b_q;
  int              stab;
  logic [2*W-1:0]  full;
  assign full  = $signed(mul_a) * $signed(mul_b);
  assign mul_p = (stab >= LATENCY) ? full[PW-1:0] : ~full[PW-1:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; stab <= 0;
    end else begin
      a_q  <= mul_a;
      b_q  <= mul_b;
      stab <= (mul_a == a_q && mul_b == b_q) ? ((stab < 100) ? stab + 1 : stab) : 1;
    end
  end

  typedef struct { int id; logic [PW-1:0] p; } exp_t;
  exp_t exp_q[$];
  int   gnt_q[$];
  int   acc_cyc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int n_acc = 0;
  int mon_g;
  logic prev_v = 1'b0;
  logic [N_REQ-1:0] hold_mask = '0;
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_prod(input int a, input int b);
    int p;
    p = a * b;
    return p[PW-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        mon_g = -1;
        for (int k = 0; k < N_REQ; k++) if (req_ready[k]) mon_g = k;
        chk("ready_onehot", $countones(req_ready), 1);
        chk("grant_id", mon_g, (gnt_q.size() > 0) ? gnt_q.pop_front() : -1);
        last_acc = cyc;
        acc_cyc_q.push_back(cyc);
      end
      if (rsp_valid && !prev_v) chk("rsp_latency", cyc - last_acc, LATENCY + 2);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_id", rsp_id, mon_e.id);
          chk("rsp_p", rsp_p, mon_e.p);
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic set_req(input int i, input int a, input int b);
    logic [31:0] av, bv;
    av = a; bv = b;
    req_a[i*W +: W] = av[W-1:0];
    req_b[i*W +: W] = bv[W-1:0];
  endtask

  // Advance one cycle; requesters that were accepted drop valid, except
  // those in hold_mask which immediately re-request.
  task automatic tick();
    logic [N_REQ-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    if (|acc) n_acc++;
    @(posedge clk);
    #1;
    req_valid = (req_valid & ~acc) | hold_mask;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(exp_q.size() == 0 && gnt_q.size() == 0 && !busy && req_valid == '0) && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n >= bound), 0);
  endtask

  task automatic single(input int id, input int a, input int b, input logic [PW-1:0] e);
    exp_t x;
    set_req(id, a, b);
    x.id = id; x.p = e;
    gnt_q.push_back(id);
    exp_q.push_back(x);
    req_valid[id] = 1'b1;
    wait_idle(40);
  endtask

  task automatic push(input int id, input int a, input int b);
    exp_t x;
    set_req(id, a, b);
    x.id = id; x.p = exp_prod(a, b);
    exp_q.push_back(x);
  endtask

  initial begin
    int s, t;
    logic [PW-1:0] hp;
    logic [IW-1:0] hid;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single request: requester 2, 5 * -3 = -15
    set_req(2, 5, -3);
    exp_q.push_back('{2, 11'h7F1});
    gnt_q.push_back(2);
    req_valid[2] = 1'b1;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    chk("single_ready_after", req_ready, 0);
    chk("single_busy", busy, 1);
    chk("single_mul_en", mul_en, 1);
    chk("single_mul_a", mul_a, 6'h05);
    chk("single_mul_b", mul_b, 6'h3D);
    wait_idle(40);
    chk("single_rsp_valid_low", rsp_valid, 0);

    // Simultaneous requests from a fresh reset
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    acc_cyc_q.delete();
    push(0, 7, 9); push(1, -4, 11); push(2, 13, -13); push(3, -31, -31);
    for (int i = 0; i < N_REQ; i++) gnt_q.push_back(i);
    req_valid = 4'b1111;
    wait_idle(80);
    chk("sim_accepts", acc_cyc_q.size(), 4);
    if (acc_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++) chk("sim_interval", acc_cyc_q[i] - acc_cyc_q[i-1], LATENCY + 3);

    // Fairness: 0 and 3 continuously valid
    push(0, 3, 4); push(3, -5, 6); push(0, 3, 4); push(3, -5, 6);
    gnt_q.push_back(0); gnt_q.push_back(3); gnt_q.push_back(0); gnt_q.push_back(3);
    s = n_acc;
    hold_mask = 4'b1001;
    req_valid = 4'b1001;
    t = 0;
    while (n_acc - s < 4 && t < 100) begin tick(); t++; end
    hold_mask = '0;
    req_valid = '0;
    chk("fair_accepts", n_acc - s, 4);
    wait_idle(40);

    // Backpressure
    rsp_ready = 1'b0;
    push(1, 10, -7); push(2, -8, 8);
    gnt_q.push_back(1); gnt_q.push_back(2);
    req_valid = 4'b0110;
    t = 0;
    while (!rsp_valid && t < 40) begin tick(); t++; end
    chk("bp_rsp_seen", rsp_valid, 1);
    hp = rsp_p; hid = rsp_id;
    chk("bp_first_p", hp, exp_prod(10, -7));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_p_hold", rsp_p, hp);
      chk("bp_id_hold", rsp_id, hid);
      chk("bp_no_accept", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_valid_drop", rsp_valid, 0);
    chk("bp_next_ready", req_ready, 4'b0100);
    rsp_ready = 1'b1;
    wait_idle(40);

    // Extremes
    single(3, 0, -32, 11'h000);
    single(0, -32, -32, 11'h400);
    single(1, 31, -32, 11'h420);
    single(2, -32, 31, 11'h420);

    // Reset in the middle of RUN
    set_req(2, 9, 9);
    gnt_q.push_back(2);
    req_valid[2] = 1'b1;
    tick();
    chk("mid_busy", busy, 1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_mul_en", mul_en, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_rsp_p", rsp_p, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mid_no_rsp", rsp_valid, 0);
    push(1, -9, 12); push(3, 6, -6);
    gnt_q.push_back(1); gnt_q.push_back(3);
    req_valid = 4'b1010;
    wait_idle(60);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
